// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_pkg
//  Description : Shared constants and Gray/binary helper functions for the
//                asynchronous FIFO pointer logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

  localparam int ADDRESS_SIZE_DEFAULT       = 3;
  localparam int ALMOST_EMPTY_LEVEL_DEFAULT = 1;

  // Helpers work on a 32-bit container; callers zero-extend narrower
  // pointers and truncate the result. Zero upper bits leave the low bits of
  // either conversion unaffected.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_to_binary.sv
`default_nettype none
// ============================================================================
//  Module      : gray_to_binary
//  Description : Purely combinational Gray-to-binary converter of parameter
//                width. Each binary bit is the XOR of all Gray bits at and
//                above it, which avoids a bit-to-bit ripple on one vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_to_binary #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_prefix_xor
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/read_pointer_status.sv
`default_nettype none
// ============================================================================
//  Module      : read_pointer_status
//  Description : Read-side pointer and status logic of an asynchronous FIFO.
//                Maintains the binary/Gray read pointer, the RAM read address
//                and registered empty / almost-empty / level flags derived
//                from the synchronised Gray write pointer.
//                Optional sticky underflow flag enabled by the macro
//                READ_POINTER_UNDERFLOW_EN (flag tied low when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module read_pointer_status
  import async_fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE       = ADDRESS_SIZE_DEFAULT,
  parameter int ALMOST_EMPTY_LEVEL = ALMOST_EMPTY_LEVEL_DEFAULT
) (
  input  logic                    read_clk,
  input  logic                    read_reset_n,
  input  logic                    read_enable,
  input  logic [ADDRESS_SIZE:0]   read_to_write_pointer,
  input  logic                    read_underflow_clear,
  output logic [ADDRESS_SIZE-1:0] read_address,
  output logic [ADDRESS_SIZE:0]   read_pointer,
  output logic                    read_empty,
  output logic                    read_almost_empty,
  output logic [ADDRESS_SIZE:0]   read_level,
  output logic                    read_underflow
);

  localparam int                PTR_W    = ADDRESS_SIZE + 1;
  localparam logic [PTR_W-1:0]  AE_LEVEL = PTR_W'(ALMOST_EMPTY_LEVEL);

  logic [PTR_W-1:0] rbin_q;
  logic [PTR_W-1:0] rbin_d;
  logic [PTR_W-1:0] rgray_d;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] level_d;
  logic             pop;

  logic [PTR_W-1:0] read_pointer_q;
  logic             read_empty_q;
  logic             read_almost_empty_q;
  logic [PTR_W-1:0] read_level_q;

  // Write pointer back to binary so the occupancy is a plain subtraction.
  gray_to_binary #(
    .WIDTH (PTR_W)
  ) u_wptr_g2b (
    .gray_i (read_to_write_pointer),
    .bin_o  (wbin)
  );

  // Next-state pointer and occupancy; a pop is ignored while empty.
  always_comb begin
    pop     = read_enable & ~read_empty_q;
    rbin_d  = rbin_q + PTR_W'(pop);
    rgray_d = PTR_W'(bin2gray(32'(rbin_d)));
    level_d = wbin - rbin_d;
  end

  // Pointer and status registers, all computed from the post-pop pointer.
  always_ff @(posedge read_clk) begin
    if (!read_reset_n) begin
      rbin_q              <= '0;
      read_pointer_q      <= '0;
      read_empty_q        <= 1'b1;
      read_almost_empty_q <= 1'b1;
      read_level_q        <= '0;
    end else begin
      rbin_q              <= rbin_d;
      read_pointer_q      <= rgray_d;
      read_empty_q        <= (rgray_d == read_to_write_pointer);
      read_almost_empty_q <= (level_d <= AE_LEVEL);
      read_level_q        <= level_d;
    end
  end

  assign read_address      = rbin_q[ADDRESS_SIZE-1:0];
  assign read_pointer      = read_pointer_q;
  assign read_empty        = read_empty_q;
  assign read_almost_empty = read_almost_empty_q;
  assign read_level        = read_level_q;

`ifdef READ_POINTER_UNDERFLOW_EN
  logic underflow_q;

  // Sticky underflow: a pop attempt while empty sets it, and set beats clear.
  always_ff @(posedge read_clk) begin
    if (!read_reset_n) begin
      underflow_q <= 1'b0;
    end else if (read_enable && read_empty_q) begin
      underflow_q <= 1'b1;
    end else if (read_underflow_clear) begin
      underflow_q <= 1'b0;
    end
  end

  assign read_underflow = underflow_q;
`else
  logic unused_underflow_clear;

  assign unused_underflow_clear = read_underflow_clear;
  assign read_underflow         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_read_pointer_status.sv
`default_nettype none
// ============================================================================
//  Module      : tb_read_pointer_status
//  Description : Self-checking bench for read_pointer_status. Directed
//                scenarios followed by random pops / write advances / resets,
//                compared against an occupancy-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_read_pointer_status;

  localparam int AS  = 3;
  localparam int AEL = 1;
  localparam int MOD = 16;   // 2**(AS+1)

  logic          read_clk = 1'b0;
  logic          read_reset_n = 1'b0;
  logic          read_enable = 1'b0;
  logic [AS:0]   read_to_write_pointer = '0;
  logic          read_underflow_clear = 1'b0;
  logic [AS-1:0] read_address;
  logic [AS:0]   read_pointer;
  logic          read_empty;
  logic          read_almost_empty;
  logic [AS:0]   read_level;
  logic          read_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: read count and flags as plain integers.
  int m_rbin  = 0;
  int m_level = 0;
  int m_empty = 1;
  int m_almost = 1;
  int m_uf    = 0;
  int w_bin   = 0;

  read_pointer_status #(
    .ADDRESS_SIZE       (AS),
    .ALMOST_EMPTY_LEVEL (AEL)
  ) dut (
    .read_clk              (read_clk),
    .read_reset_n          (read_reset_n),
    .read_enable           (read_enable),
    .read_to_write_pointer (read_to_write_pointer),
    .read_underflow_clear  (read_underflow_clear),
    .read_address          (read_address),
    .read_pointer          (read_pointer),
    .read_empty            (read_empty),
    .read_almost_empty     (read_almost_empty),
    .read_level            (read_level),
    .read_underflow        (read_underflow)
  );

  always #5 read_clk = ~read_clk;

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the model, check
  // every output just after the rising edge.
  task automatic step(input bit rst_n, input bit en, input int wb, input bit clr, input string tag);
    int old_empty;
    int pop;
    @(negedge read_clk);
    read_reset_n          = rst_n;
    read_enable           = en;
    w_bin                 = wb % MOD;
    read_to_write_pointer = 4'(to_gray(w_bin));
    read_underflow_clear  = clr;

    old_empty = m_empty;
    if (!rst_n) begin
      m_rbin = 0; m_level = 0; m_empty = 1; m_almost = 1; m_uf = 0;
    end else begin
      pop      = (en && old_empty == 0) ? 1 : 0;
      m_rbin   = (m_rbin + pop) % MOD;
      m_level  = (w_bin - m_rbin + MOD) % MOD;
      m_empty  = (m_level == 0) ? 1 : 0;
      m_almost = (m_level <= AEL) ? 1 : 0;
`ifdef READ_POINTER_UNDERFLOW_EN
      if (en && old_empty == 1) m_uf = 1;
      else if (clr) m_uf = 0;
`endif
    end

    @(posedge read_clk);
    #1;
    check({tag, ".address"}, 32'(read_address),      32'(m_rbin % 8));
    check({tag, ".pointer"}, 32'(read_pointer),      32'(to_gray(m_rbin)));
    check({tag, ".empty"},   32'(read_empty),        32'(m_empty));
    check({tag, ".almost"},  32'(read_almost_empty), 32'(m_almost));
    check({tag, ".level"},   32'(read_level),        32'(m_level));
    check({tag, ".uflow"},   32'(read_underflow),    32'(m_uf));
  endtask

  initial begin
    int occ;
    int room;
    int adv;
    bit rst_n;
    bit en;
    bit clr;

    // Reset with write pointer at zero.
    step(0, 0, 0, 0, "reset0");
    step(0, 0, 0, 0, "reset1");
    check("reset.level_const", 32'(read_level), 32'd0);
    check("reset.pointer_const", 32'(read_pointer), 32'd0);

    // Level / almost-empty: write pointer Gray 0010 (binary 3).
    step(1, 0, 3, 0, "lvl3");
    check("lvl3.level_const", 32'(read_level), 32'd3);
    step(1, 1, 3, 0, "pop1");
    step(1, 1, 3, 0, "pop2");
    check("pop2.almost_const", 32'(read_almost_empty), 32'd1);
    step(1, 1, 3, 0, "pop3");
    check("pop3.pointer_const", 32'(read_pointer), 32'b0010);

    // Underflow: three pops while empty, clear, then set-versus-clear.
    step(1, 1, 3, 0, "uf0");
    step(1, 1, 3, 0, "uf1");
    step(1, 1, 3, 0, "uf2");
    check("uf.address_hold", 32'(read_address), 32'd3);
    step(1, 0, 3, 0, "uf_hold");
    step(1, 0, 3, 1, "uf_clr");
    step(1, 1, 3, 1, "uf_setclr");
    step(1, 0, 3, 1, "uf_clr2");

    // Full FIFO: reset, write pointer Gray 1100 (binary 8), eight pops.
    step(0, 0, 0, 0, "full_rst");
    step(1, 0, 8, 0, "full");
    check("full.level_const", 32'(read_level), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check("full.addr_seq", 32'(read_address), 32'(k));
      step(1, 1, 8, 0, "full_pop");
    end
    check("full.empty_const", 32'(read_empty), 32'd1);

    // Wrap-around: bring rbin to 7, write pointer to binary 10, pop once.
    step(0, 0, 0, 0, "wrap_rst");
    step(1, 0, 7, 0, "wrap_fill");
    for (int k = 0; k < 7; k++) step(1, 1, 7, 0, "wrap_drain");
    step(1, 0, 10, 0, "wrap_w10");
    step(1, 1, 10, 0, "wrap_pop");
    check("wrap.pointer_const", 32'(read_pointer), 32'b1100);
    check("wrap.level_const", 32'(read_level), 32'd2);
    step(0, 1, 10, 0, "wrap_midrst");

    // Random traffic keeping occupancy within the FIFO depth.
    w_bin = 0;
    step(1, 0, 0, 0, "rnd_start");
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      en    = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 7) == 0);
      if (!rst_n) begin
        step(0, en, 0, clr, "rnd_rst");
      end else begin
        occ  = (w_bin - m_rbin + MOD) % MOD;
        room = 8 - occ;
        adv  = (room > 0) ? int'($urandom_range(0, (room > 2) ? 2 : room)) : 0;
        step(1, en, w_bin + adv, clr, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
